pal_upload: RTL and testbench

- Bus initiator that fills the palette RAM in the colour block through that block's CPU-side port (AB, COLCS, NLWR, NREAD, CPU_DIN).
- Each 16-bit palette word is fetched from a source with a req/ack handshake, then issued as two byte writes: high byte with AB[1]=0, low byte with AB[1]=1.
- Used at boot and for palette fades without CPU involvement; a bus request/grant pair arbitrates with the 68000.

---
 rtl/pal_upload_pkg.sv | 46 ++++
 rtl/pal_upload_if.sv | 24 ++
 rtl/pal_upload_byte_wr.sv | 57 +++++
 rtl/pal_upload.sv | 156 +++++++++++++++
 tb/tb_pal_upload.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pal_upload_pkg.sv
// Shared types and constants for the palette upload initiator.
package pal_upload_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARB,
        S_FETCH,
        S_WAITBLK,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_NEXT,
        S_FIN
    } pal_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD
    } wr_phase_t;

    localparam int PAL_WORDS = 2048;
    localparam int PAL_IDX_W = $clog2(PAL_WORDS);

    // Byte select as seen on AB[1]
    localparam logic HI = 1'b0;
    localparam logic LO = 1'b1;

    localparam int R_LSB = 0;
    localparam int R_MSB = 4;
    localparam int G_LSB = 5;
    localparam int G_MSB = 9;
    localparam int B_LSB = 10;
    localparam int B_MSB = 14;

    function automatic logic [PAL_IDX_W-1:0] pal_word_idx(input logic [PAL_IDX_W-1:0] base,
                                                          input logic [11:0] n);
        return base + n[PAL_IDX_W-1:0];
    endfunction

    function automatic logic [7:0] pal_byte(input logic [15:0] word, input logic half);
        return (half == HI) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/pal_upload_if.sv
// Source-fetch handshake and colour-block CPU-side palette bus.
interface pal_upload_if #(
    parameter int SRC_AW = 12
);
    logic              SRC_REQ;
    logic [SRC_AW-1:0] SRC_ADDR;
    logic              SRC_ACK;
    logic [15:0]       SRC_DATA;
    logic [12:1]       AB;
    logic              COLCS;
    logic              NLWR;
    logic              NREAD;
    logic [7:0]        CPU_DIN;

    modport master (
        output SRC_REQ, SRC_ADDR, AB, COLCS, NLWR, NREAD, CPU_DIN,
        input  SRC_ACK, SRC_DATA
    );

    modport slave (
        input  SRC_REQ, SRC_ADDR, AB, COLCS, NLWR, NREAD, CPU_DIN,
        output SRC_ACK, SRC_DATA
    );
endinterface

// File: rtl/pal_upload_byte_wr.sv
// Three-cycle palette byte write: SETUP (CS low), STROBE (WR low), HOLD (WR high).
module pal_byte_wr
    import pal_upload_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [PAL_IDX_W-1:0] addr,
    input  logic                 sel,
    input  logic [7:0]           data,
    output logic                 done,
    output logic                 colcs,
    output logic                 nlwr,
    output logic [11:0]          ab,
    output logic [7:0]           cpu_din
);

    wr_phase_t phase;

    assign done = (phase == WR_HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= WR_IDLE;
            colcs   <= 1'b1;
            nlwr    <= 1'b1;
            ab      <= '0;
            cpu_din <= '0;
        end else begin
            case (phase)
                WR_IDLE: begin
                    if (start) begin
                        ab      <= {addr, sel};
                        cpu_din <= data;
                        colcs   <= 1'b0;
                        nlwr    <= 1'b1;
                        phase   <= WR_SETUP;
                    end
                end
                WR_SETUP: begin
                    nlwr  <= 1'b0;
                    phase <= WR_STROBE;
                end
                WR_STROBE: begin
                    nlwr  <= 1'b1;
                    phase <= WR_HOLD;
                end
                WR_HOLD: begin
                    colcs <= 1'b1;
                    phase <= WR_IDLE;
                end
                default: phase <= WR_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pal_upload.sv
// Palette upload initiator: fetches 16-bit words and writes them as two bytes
// into the colour-block palette RAM after winning the CPU bus.
module pal_upload
    import pal_upload_pkg::*;
#(
    parameter bit BLANK_ONLY = 1'b1,
    parameter int SRC_AW     = 12
) (
    input  logic              V6M,
    input  logic              nRESET,
    input  logic              START,
    input  logic [10:0]       BASE,
    input  logic [11:0]       COUNT,
    input  logic [SRC_AW-1:0] SRC_BASE,
    input  logic              NCBLK,
    output logic              BR,
    input  logic              BG,
    output logic              BUSY,
    output logic              DONE,
    pal_upload_if.master      bus
);

    pal_state_t        state;
    logic [10:0]       base_q;
    logic [11:0]       count_q;
    logic [11:0]       n;
    logic [SRC_AW-1:0] src_base_q;
    logic [SRC_AW-1:0] src_addr_q;
    logic              src_req_q;
    logic [15:0]       word_q;
    logic              half;

    logic              wr_ok;
    logic              wr_start;
    logic              wr_done;
    logic [10:0]       wr_addr;
    logic [7:0]        wr_data;
    logic              colcs;
    logic              nlwr;
    logic [11:0]       ab;
    logic [7:0]        cpu_din;
    logic [11:0]       n_next;

    // A lost grant parks the sequencer here between bytes, bus released.
    assign wr_ok    = BG && (!BLANK_ONLY || !NCBLK);
    assign wr_start = (state == S_WAITBLK) && wr_ok;
    assign wr_addr  = pal_word_idx(base_q, n);
    assign wr_data  = pal_byte(word_q, half);
    assign n_next   = n + 12'd1;

    assign bus.SRC_REQ  = src_req_q;
    assign bus.SRC_ADDR = src_addr_q;
    assign bus.COLCS    = colcs;
    assign bus.NLWR     = nlwr;
    assign bus.NREAD    = 1'b1;
    assign bus.AB       = ab;
    assign bus.CPU_DIN  = cpu_din;

    pal_byte_wr u_byte_wr (
        .clk     (V6M),
        .rst_n   (nRESET),
        .start   (wr_start),
        .addr    (wr_addr),
        .sel     (half),
        .data    (wr_data),
        .done    (wr_done),
        .colcs   (colcs),
        .nlwr    (nlwr),
        .ab      (ab),
        .cpu_din (cpu_din)
    );

    always_ff @(posedge V6M or negedge nRESET) begin
        if (!nRESET) begin
            state      <= S_IDLE;
            BR         <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            src_req_q  <= 1'b0;
            src_addr_q <= '0;
            base_q     <= '0;
            count_q    <= '0;
            src_base_q <= '0;
            word_q     <= '0;
            half       <= HI;
            n          <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        n <= '0;
                        if (COUNT == 12'd0) begin
                            state <= S_FIN;
                        end else begin
                            base_q     <= BASE;
                            count_q    <= COUNT;
                            src_base_q <= SRC_BASE;
                            BUSY       <= 1'b1;
                            BR         <= 1'b1;
                            state      <= S_ARB;
                        end
                    end
                end
                S_ARB: begin
                    if (BG) begin
                        src_req_q  <= 1'b1;
                        src_addr_q <= src_base_q + SRC_AW'(n);
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.SRC_ACK) begin
                        word_q    <= bus.SRC_DATA;
                        src_req_q <= 1'b0;
                        half      <= HI;
                        state     <= S_WAITBLK;
                    end
                end
                S_WAITBLK: begin
                    if (wr_start) state <= S_SETUP;
                end
                S_SETUP:  state <= S_STROBE;
                S_STROBE: state <= S_HOLD;
                S_HOLD: begin
                    if (wr_done) begin
                        if (half == HI) begin
                            half  <= LO;
                            state <= S_WAITBLK;
                        end else begin
                            state <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    n <= n_next;
                    if (n_next == count_q) begin
                        state <= S_FIN;
                    end else begin
                        src_req_q  <= 1'b1;
                        src_addr_q <= src_base_q + SRC_AW'(n_next);
                        state      <= S_FETCH;
                    end
                end
                S_FIN: begin
                    BR    <= 1'b0;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pal_upload.sv
// Scoreboard bench for pal_upload: one instance per BLANK_ONLY setting.
module tb_pal_upload;
    import pal_upload_pkg::*;

    typedef struct packed {
        logic [10:0] idx;
        logic        sel;
        logic [7:0]  data;
    } exp_t;

    typedef struct packed {
        logic        br;
        logic        busy;
        logic        done;
        logic        src_req;
        logic [11:0] src_addr;
        logic        colcs;
        logic        nlwr;
        logic        nread;
        logic [11:0] ab;
        logic [7:0]  din;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic [10:0] base;
    logic [11:0] count;
    logic [11:0] sbase;
    logic        ncblk, bg;
    logic        br_a, br_b, busy_a, busy_b, done_a, done_b;

    pal_upload_if #(.SRC_AW(12)) bus_a ();
    pal_upload_if #(.SRC_AW(12)) bus_b ();

    pal_upload #(.BLANK_ONLY(1'b0), .SRC_AW(12)) dut_a (
        .V6M(clk), .nRESET(rst_n), .START(start_a), .BASE(base), .COUNT(count),
        .SRC_BASE(sbase), .NCBLK(ncblk), .BR(br_a), .BG(bg), .BUSY(busy_a),
        .DONE(done_a), .bus(bus_a.master)
    );

    pal_upload #(.BLANK_ONLY(1'b1), .SRC_AW(12)) dut_b (
        .V6M(clk), .nRESET(rst_n), .START(start_b), .BASE(base), .COUNT(count),
        .SRC_BASE(sbase), .NCBLK(ncblk), .BR(br_b), .BG(bg), .BUSY(busy_b),
        .DONE(done_b), .bus(bus_b.master)
    );

    always #5 clk = ~clk;

    // Arbiter contract: once granted, BG stays up until BR is released.
    assert property (@(posedge clk) disable iff (!rst_n) (br_a && bg) |=> (bg || !br_a))
        else $error("FAIL bg_held_a: BG dropped while granted, required 1");
    assert property (@(posedge clk) disable iff (!rst_n) (br_b && bg) |=> (bg || !br_b))
        else $error("FAIL bg_held_b: BG dropped while granted, required 1");

    exp_t       exp_q[$];
    logic [7:0] ram_hi[PAL_WORDS];
    logic [7:0] ram_lo[PAL_WORDS];
    int         checks = 0;
    int         failures = 0;

    int   pulses, done_cnt, done_cycle, first_setup, strobe_c, setup_after_pulse;
    bit   br_gap, act_early, any_br, any_cs, any_req, busy_c1, aborted;
    obs_t obs_rst;

    task automatic observe(input int d, output obs_t o);
        if (d == 0) begin
            o = {br_a, busy_a, done_a, bus_a.SRC_REQ, bus_a.SRC_ADDR, bus_a.COLCS,
                 bus_a.NLWR, bus_a.NREAD, bus_a.AB, bus_a.CPU_DIN};
        end else begin
            o = {br_b, busy_b, done_b, bus_b.SRC_REQ, bus_b.SRC_ADDR, bus_b.COLCS,
                 bus_b.NLWR, bus_b.NREAD, bus_b.AB, bus_b.CPU_DIN};
        end
    endtask

    task automatic set_start(input int d, input logic v);
        if (d == 0) start_a = v;
        else        start_b = v;
    endtask

    task automatic set_ack(input int d, input logic v, input logic [15:0] w);
        if (d == 0) begin bus_a.SRC_ACK = v; bus_a.SRC_DATA = w; end
        else        begin bus_b.SRC_ACK = v; bus_b.SRC_DATA = w; end
    endtask

    // Drives one job, answers source fetches, scoreboards every strobe.
    task automatic run_job(input int d, input logic [10:0] b, input logic [11:0] cnt,
                           input logic [11:0] sb, input logic [15:0] w0, input logic [15:0] w1,
                           input int ncblk_init, input int bg_low, input int pulse_len,
                           input bit rst_strobe, input int restart_cycle);
        obs_t        o;
        exp_t        e;
        int          fetched, pulse_left;
        bit          pulsed, prev_nlwr, prev_colcs, ack_now;
        logic [15:0] w;
        logic [11:0] exp_addr;
        logic [10:0] idx;

        pulses = 0; done_cnt = 0; done_cycle = -1; first_setup = -1;
        strobe_c = -1; setup_after_pulse = -1;
        br_gap = 0; act_early = 0; any_br = 0; any_cs = 0; any_req = 0; busy_c1 = 0; aborted = 0;
        exp_q.delete();
        for (int i = 0; i < PAL_WORDS; i++) begin ram_hi[i] = 8'h00; ram_lo[i] = 8'h00; end
        fetched = 0; pulse_left = 0; pulsed = 0; prev_nlwr = 1; prev_colcs = 1; ack_now = 0;

        @(negedge clk);
        base = b; count = cnt; sbase = sb;
        set_start(d, 1'b1);
        bg = (bg_low == 0);
        ncblk = (ncblk_init > 0);

        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            set_start(d, 1'b0);
            if (c == restart_cycle) begin
                base = b ^ 11'h155; count = 12'd1; sbase = sb ^ 12'hA5A;
                set_start(d, 1'b1);
            end
            observe(d, o);
            if (c == 1) busy_c1 = o.busy;
            any_br  |= o.br;
            any_cs  |= !o.colcs;
            any_req |= o.src_req;

            if (rst_strobe && o.nlwr == 1'b0) begin
                rst_n = 1'b0;
                #1;
                observe(d, obs_rst);
                set_ack(d, 1'b0, 16'h0000);
                aborted = 1;
                return;
            end

            if (ack_now) begin
                set_ack(d, 1'b0, 16'h0000);
                ack_now = 0;
            end else if (o.src_req) begin
                exp_addr = sb + 12'(fetched);
                checks++;
                if (o.src_addr !== exp_addr) begin
                    failures++;
                    $display("FAIL src_addr: word %0d got %h required %h", fetched, o.src_addr, exp_addr);
                end
                w = (fetched == 0) ? w0 : (fetched == 1) ? w1 : (w0 ^ 16'(fetched));
                idx = b + 11'(fetched);
                exp_q.push_back({idx, HI, w[15:8]});
                exp_q.push_back({idx, LO, w[7:0]});
                set_ack(d, 1'b1, w);
                ack_now = 1;
                fetched++;
            end

            if (c <= bg_low) begin
                if (!o.br) br_gap = 1;
                if (!o.colcs || o.src_req) act_early = 1;
            end

            if (!o.colcs && prev_colcs) begin
                if (first_setup < 0) first_setup = c;
                if (pulsed && setup_after_pulse < 0) setup_after_pulse = c;
                if (d == 1) begin
                    checks++;
                    if (ncblk !== 1'b0) begin
                        failures++;
                        $display("FAIL blank_gate: cycle %0d write began with NCBLK=%b required 0", c, ncblk);
                    end
                end
            end

            if (o.nlwr == 1'b0) begin
                pulses++;
                checks++;
                if (!prev_nlwr) begin
                    failures++;
                    $display("FAIL nlwr_width: cycle %0d NLWR low for 2+ cycles, required 1", c);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL write_unexpected: AB=%h DIN=%h required none", o.ab, o.din);
                end else begin
                    e = exp_q.pop_front();
                    if ({o.ab, o.din, o.colcs, o.nread} !== {e.idx, e.sel, e.data, 1'b0, 1'b1}) begin
                        failures++;
                        $display("FAIL write: AB=%h DIN=%h CS=%b RD=%b required AB=%h DIN=%h CS=0 RD=1",
                                 o.ab, o.din, o.colcs, o.nread, {e.idx, e.sel}, e.data);
                    end
                end
                if (o.ab[0] == HI) ram_hi[o.ab[11:1]] = o.din;
                else               ram_lo[o.ab[11:1]] = o.din;
                if (!pulsed && pulse_len > 0) begin
                    pulsed = 1;
                    pulse_left = pulse_len;
                    strobe_c = c;
                end
            end

            if (o.done) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = c;
            end

            ncblk = (c < ncblk_init) || (pulse_left > 0);
            if (pulse_left > 0) pulse_left--;
            bg = (c >= bg_low);
            prev_nlwr = o.nlwr;
            prev_colcs = o.colcs;
            if (done_cycle >= 0 && c >= done_cycle + 3) break;
        end

        checks++;
        if (done_cycle < 0) begin
            failures++;
            $display("FAIL done_timeout: no DONE within 600 cycles, required DONE");
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL writes_missing: %0d expected writes left, required 0", exp_q.size());
        end
        bg = 1'b1;
        ncblk = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            observe(d, o);
            checks++;
            if ({o.br, o.src_req, o.colcs, o.nlwr, o.nread, o.ab, o.din, o.busy, o.done} !==
                {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 8'h00, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL reset_state: dut %0d BR=%b REQ=%b CS=%b WR=%b RD=%b AB=%h DIN=%h BUSY=%b DONE=%b required 0 0 1 1 1 000 00 0 0",
                         d, o.br, o.src_req, o.colcs, o.nlwr, o.nread, o.ab, o.din, o.busy, o.done);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_job(0, 11'h010, 12'd2, 12'h000, 16'h7FFF, 16'h001F, 0, 0, 0, 0, -1);
        checks++;
        if ({ram_hi[11'h010], ram_lo[11'h010], ram_hi[11'h011], ram_lo[11'h011]} !== 32'h7FFF_001F) begin
            failures++;
            $display("FAIL basic_ram: got %h%h%h%h required 7fff001f",
                     ram_hi[11'h010], ram_lo[11'h010], ram_hi[11'h011], ram_lo[11'h011]);
        end
        checks++;
        if (pulses != 4) begin failures++; $display("FAIL basic_pulses: got %0d required 4", pulses); end
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL basic_done_once: got %0d required 1", done_cnt); end
        checks++;
        if (busy_c1 !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b required 1", busy_c1); end
    endtask

    task automatic test_count_zero();
        run_job(0, 11'h123, 12'd0, 12'h000, 16'h0000, 16'h0000, 0, 0, 0, 0, -1);
        checks++;
        if (done_cycle != 2) begin failures++; $display("FAIL zero_done_latency: got %0d required 2", done_cycle); end
        checks++;
        if ({any_br, any_cs, any_req} !== 3'b000) begin
            failures++;
            $display("FAIL zero_no_bus: BR/CS/REQ seen %b%b%b required 000", any_br, any_cs, any_req);
        end
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL zero_done_once: got %0d required 1", done_cnt); end
    endtask

    task automatic test_wrap();
        run_job(0, 11'h7FF, 12'd2, 12'hFFF, 16'hA5C3, 16'h3C5A, 0, 0, 0, 0, -1);
        checks++;
        if ({ram_hi[11'h7FF], ram_lo[11'h7FF], ram_hi[11'h000], ram_lo[11'h000]} !== 32'hA5C3_3C5A) begin
            failures++;
            $display("FAIL wrap_ram: got %h%h%h%h required a5c33c5a",
                     ram_hi[11'h7FF], ram_lo[11'h7FF], ram_hi[11'h000], ram_lo[11'h000]);
        end
    endtask

    task automatic test_start_busy();
        run_job(0, 11'h200, 12'd2, 12'h300, 16'h1111, 16'h2222, 0, 0, 0, 0, 4);
        checks++;
        if ({ram_hi[11'h200], ram_lo[11'h200], ram_hi[11'h201], ram_lo[11'h201]} !== 32'h1111_2222) begin
            failures++;
            $display("FAIL busy_start_ram: got %h%h%h%h required 11112222",
                     ram_hi[11'h200], ram_lo[11'h200], ram_hi[11'h201], ram_lo[11'h201]);
        end
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL busy_start_done: got %0d required 1", done_cnt); end
    endtask

    task automatic test_blank();
        run_job(1, 11'h100, 12'd2, 12'h040, 16'h1234, 16'h5678, 100, 0, 5, 0, -1);
        checks++;
        if (first_setup != 101) begin
            failures++;
            $display("FAIL blank_first_setup: cycle %0d required 101", first_setup);
        end
        checks++;
        if (setup_after_pulse != strobe_c + 6) begin
            failures++;
            $display("FAIL blank_stall: next setup cycle %0d required %0d", setup_after_pulse, strobe_c + 6);
        end
        checks++;
        if ({ram_hi[11'h100], ram_lo[11'h100], ram_hi[11'h101], ram_lo[11'h101]} !== 32'h1234_5678) begin
            failures++;
            $display("FAIL blank_ram: got %h%h%h%h required 12345678",
                     ram_hi[11'h100], ram_lo[11'h100], ram_hi[11'h101], ram_lo[11'h101]);
        end
    endtask

    task automatic test_bg_wait();
        run_job(1, 11'h300, 12'd1, 12'h000, 16'hBEEF, 16'h0000, 0, 20, 0, 0, -1);
        checks++;
        if ({br_gap, act_early} !== 2'b00) begin
            failures++;
            $display("FAIL bg_wait_idle: br_gap=%b activity=%b required 0 0", br_gap, act_early);
        end
        checks++;
        if (first_setup < 22) begin
            failures++;
            $display("FAIL bg_setup_delay: setup cycle %0d required >= 22", first_setup);
        end
        checks++;
        if ({ram_hi[11'h300], ram_lo[11'h300]} !== 16'hBEEF) begin
            failures++;
            $display("FAIL bg_ram: got %h%h required beef", ram_hi[11'h300], ram_lo[11'h300]);
        end
    endtask

    task automatic test_reset_mid();
        run_job(0, 11'h055, 12'd2, 12'h010, 16'h1357, 16'h2468, 0, 0, 0, 1, -1);
        checks++;
        if ({aborted, obs_rst.colcs, obs_rst.nlwr, obs_rst.br} !== 4'b1110) begin
            failures++;
            $display("FAIL reset_mid_release: hit=%b CS=%b WR=%b BR=%b required 1 1 1 0",
                     aborted, obs_rst.colcs, obs_rst.nlwr, obs_rst.br);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_job(0, 11'h055, 12'd2, 12'h010, 16'h1357, 16'h2468, 0, 0, 0, 0, -1);
        checks++;
        if ({ram_hi[11'h055], ram_lo[11'h055], ram_hi[11'h056], ram_lo[11'h056]} !== 32'h1357_2468) begin
            failures++;
            $display("FAIL reset_mid_rerun: got %h%h%h%h required 13572468",
                     ram_hi[11'h055], ram_lo[11'h055], ram_hi[11'h056], ram_lo[11'h056]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        base = '0; count = '0; sbase = '0;
        ncblk = 1'b0; bg = 1'b1;
        bus_a.SRC_ACK = 1'b0; bus_a.SRC_DATA = '0;
        bus_b.SRC_ACK = 1'b0; bus_b.SRC_DATA = '0;

        test_reset();
        test_basic();
        test_count_zero();
        test_wrap();
        test_start_busy();
        test_blank();
        test_bg_wait();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
